serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 d  output  WIDTH  registered difference, a - b - bin modulo 2^WIDTH.
REQ-010 bout  output  1  registered borrow-out; 1 when a < b + bin, unsigned.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  single-cycle pulse; d and bout are valid from this cycle on.
REQ-013 ovf  output  1  signed two's-complement overflow; present only per REQ-027.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> RUN on start=1; otherwise DONE -> IDLE.
REQ-015 Accepting start (in IDLE or DONE) SHALL latch a, b and bin into internal operand registers and clear the internal bit counter.
REQ-016 start while in RUN SHALL be ignored; the latched operands SHALL NOT change.
REQ-017 RUN SHALL process one bit per clock, LSB first.
- diff_i = a_i ^ b_i ^ br.
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
- br is initialised to bin.
REQ-018 Partial results SHALL accumulate in an internal shift register; d and bout SHALL update only on the edge that enters DONE and SHALL otherwise hold their value.
REQ-019 Latency: start accepted at edge 0 -> busy=1 from edge 0 -> d, bout and done valid after edge WIDTH (WIDTH+1 cycles start-to-done).
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-021 Back-to-back: start asserted during DONE SHALL begin the next operation with no idle cycle; the previous d and bout SHALL hold until the next DONE.
REQ-022 Inputs a, b and bin SHALL be don't-care except on the edge where start is accepted.

Reset
REQ-023 rst_n=0 SHALL immediately force the following, independent of clk:
- state=IDLE;
- d=0, bout=0, busy=0, done=0, ovf=0;
- bit counter, borrow and operand/shift registers cleared.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; done SHALL NOT pulse for the aborted operation.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro SUB_OVERFLOW_EN.
REQ-027 With SUB_OVERFLOW_EN defined:
- port ovf exists;
- ovf updates together with d;
- ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), using the latched operands;
- ovf is held between operations.
REQ-028 Without SUB_OVERFLOW_EN:
- port ovf and its logic are absent;
- all other behaviour and timing are identical.

Verification
REQ-029 Basic unsigned: WIDTH=4, a=1000, b=0011, bin=0 -> after 5 cycles done=1, d=0101, bout=0.
REQ-030 Borrow wrap: a=0011, b=1000, bin=0 -> d=1011, bout=1; then a=0111, b=0111, bin=1 -> d=1111, bout=1; then a=0, b=0, bin=0 -> d=0000, bout=0.
REQ-031 Overflow (SUB_OVERFLOW_EN defined): a=0111, b=1000, bin=0 -> d=1111, bout=1, ovf=1; then a=0101, b=0011 -> d=0010, ovf=0.
REQ-032 Protocol: start held high through RUN with changing a and b -> result matches the operands latched at the first accept; done is one cycle wide; back-to-back start in DONE -> busy=1 on the next cycle.
REQ-033 Reset mid-operation: rst_n pulsed low at bit-cycle 2 -> all outputs 0 immediately, no done pulse; a new start after release -> correct result.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
//   over WIDTH cycles. The result and borrow-out are registered and held
//   between operations.
//
//   Optional feature macro: SUB_OVERFLOW_EN adds the ovf port, a signed
//   two's-complement overflow flag that updates with d.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a subtraction (accepted in IDLE or DONE, ignored in RUN)
//   a      in   minuend [WIDTH]
//   b      in   subtrahend [WIDTH]
//   bin    in   borrow-in
//   d      out  registered difference [WIDTH]
//   bout   out  registered borrow-out
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse when d/bout have just been updated
//   ovf    out  signed overflow (only with SUB_OVERFLOW_EN)
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_ai;
  logic             w_bi;
  logic             w_diff;
  logic             w_br_next;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_last;
  logic             w_accept;

  assign w_ai      = r_a[r_cnt];
  assign w_bi      = r_b[r_cnt];
  assign w_diff    = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  // Newest bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  // r_sh holds only WIDTH-1 bits since the final bit goes straight to d.
  assign w_sh_next = {w_diff, r_sh};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_accept  = start && (r_state != RUN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_sh   <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (r_state == RUN) begin
      r_sh  <= w_sh_next[WIDTH-1:1];
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_d    <= w_sh_next;
        r_bout <= w_br_next;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic r_ovf;

  // w_diff on the last bit-cycle is the MSB of the new difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == RUN) && w_last) begin
      r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign d    = r_d;
  assign bout = r_bout;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=4): directed vectors, protocol and
// reset cases, then randomized operations compared to an arithmetic model.
// Define SUB_OVERFLOW_EN to also check ovf.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
  logic         prev_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_d;
  logic         prev_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] ed, input logic eb,
                            input logic ebusy, input logic edone);
    check({tag, "_d"},    32'(d),    32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_busy"}, 32'(busy), 32'(ebusy));
    check({tag, "_done"}, 32'(done), 32'(edone));
  endtask

  task automatic randomize_inputs();
    a   = W'($urandom_range(0, (1 << W) - 1));
    b   = W'($urandom_range(0, (1 << W) - 1));
    bin = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge. Presents one operation, follows it through RUN and
  // checks the result in DONE; returns at the DONE negedge with start=0.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                    input bit hold, input string tag);
    int           diff;
    logic [W-1:0] ed;
    logic         eb;
    diff = int'(ta) - int'(tb_) - int'(tbin);
    ed   = diff[W-1:0];
    eb   = (diff < 0);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    bin   = tbin;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      check_outs({tag, "_run"}, prev_d, prev_bout, 1'b1, 1'b0);
`ifdef SUB_OVERFLOW_EN
      check({tag, "_run_ovf"}, 32'(ovf), 32'(prev_ovf));
`endif
      start = hold;
      randomize_inputs();
    end
    @(negedge clk);
    check_outs({tag, "_res"}, ed, eb, 1'b0, 1'b1);
`ifdef SUB_OVERFLOW_EN
    begin
      logic eo;
      eo = (ta[W-1] != tb_[W-1]) && (ed[W-1] != ta[W-1]);
      check({tag, "_res_ovf"}, 32'(ovf), 32'(eo));
      prev_ovf = eo;
    end
`endif
    prev_d    = ed;
    prev_bout = eb;
    start     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outs("idle", prev_d, prev_bout, 1'b0, 1'b0);
`ifdef SUB_OVERFLOW_EN
      check("idle_ovf", 32'(ovf), 32'(prev_ovf));
`endif
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    prev_d    = '0;
    prev_bout = 1'b0;
`ifdef SUB_OVERFLOW_EN
    prev_ovf  = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    check_outs("reset", '0, 1'b0, 1'b0, 1'b0);
`ifdef SUB_OVERFLOW_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Directed vectors
    op(4'b1000, 4'b0011, 1'b0, 1'b0, "basic");
    idle(1);
    op(4'b0011, 4'b1000, 1'b0, 1'b0, "wrap1");
    op(4'b0111, 4'b0111, 1'b1, 1'b0, "wrap2");
    op(4'b0000, 4'b0000, 1'b0, 1'b0, "zero");
    idle(1);
    op(4'b0111, 4'b1000, 1'b0, 1'b0, "ovf1");
    op(4'b0101, 4'b0011, 1'b0, 1'b0, "ovf2");
    idle(1);

    // start held through RUN with changing operands, then back-to-back
    op(4'b1001, 4'b0100, 1'b1, 1'b1, "hold");
    op(4'b0011, 4'b1100, 1'b0, 1'b1, "b2b");
    idle(2);

    // Reset during bit-cycle 2
    start = 1'b1;
    a     = 4'b1010;
    b     = 4'b0001;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_mid", '0, 1'b0, 1'b0, 1'b0);
`ifdef SUB_OVERFLOW_EN
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    prev_ovf = 1'b0;
`endif
    prev_d    = '0;
    prev_bout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(int'(W) + 2);
    op(4'b1010, 4'b0001, 1'b0, 1'b0, "after_rst");
    idle(1);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      bit           rhold;
      ra    = W'($urandom_range(0, (1 << W) - 1));
      rb    = W'($urandom_range(0, (1 << W) - 1));
      rbin  = 1'($urandom_range(0, 1));
      rhold = 1'($urandom_range(0, 1));
      op(ra, rb, rbin, rhold, "rand");
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
